seq_div: RTL



---
 rtl/rv_arith_pkg.sv | 18 +
 rtl/seq_div_if.sv | 27 ++
 rtl/div_step.sv | 27 ++
 rtl/seq_div.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rv_arith_pkg.sv
// Shared definitions for the execute-stage sequential arithmetic units
// (multiplier and divider): default datapath width and FSM state encodings.
package rv_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

    // Width of an iteration counter that must reach `width` without wrapping.
    function automatic int unsigned iter_cnt_bits(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_div_if.sv
// start/busy/done handshake bundle between the execute stage (master)
// and the sequential divider (slave).
interface seq_div_if
    import rv_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    modport master (
        output start, a, b,
        input  busy, done, q, r
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// try to subtract the divisor, keep the difference if it did not borrow.
module div_step
    import rv_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             din_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;

    // rem_i < divisor_i always holds, so partial < 2*divisor and the top
    // bit of the WIDTH+1-bit difference is exactly the borrow.
    always_comb begin
        partial = {rem_i, din_i};
        trial   = partial - {1'b0, divisor_i};
        q_bit_o = ~trial[WIDTH];
        rem_o   = q_bit_o ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider: one quotient bit per clock using div_step,
// RISC-V DIVU/REMU divide-by-zero results, start/busy/done handshake.
module seq_div
    import rv_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic      Clk,
    input  logic      Rst,
    seq_div_if.slave  bus
);

    localparam int unsigned          CNT_W     = iter_cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(WIDTH - 1);

    arith_state_e       state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic [2*WIDTH-1:0] work_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (work_q[2*WIDTH-1:WIDTH]),
        .din_i     (work_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // High half: partial remainder; low half: remaining dividend bits
    // shifted up while quotient bits fill in from the bottom.
    assign work_next = {step_rem, work_q[WIDTH-2:0], step_qbit};

    always_comb begin
        // NOTE: every _d signal gets a default before the case so no path
        // through this block can infer a latch.
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        q_d       = q_q;
        r_d       = r_q;
        divisor_d = divisor_q;
        work_d    = work_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    divisor_d = bus.b;
                    work_d    = {{WIDTH{1'b0}}, bus.a};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_CALC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_CALC: begin
                if (divisor_q == '0) begin
                    // A zero divisor resolves in its first CALC cycle, so
                    // done still rises on the edge after acceptance.
                    q_d     = '1;
                    r_d     = work_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    work_d = work_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        q_d     = work_next[WIDTH-1:0];
                        r_d     = work_next[2*WIDTH-1:WIDTH];
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state is written only with non-blocking
        // assignments so every flop samples pre-edge values.
        if (!Rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            divisor_q <= '0;
            // NOTE: the working register is cleared like any other flop so
            // an aborted run leaves no stale partial remainder behind.
            work_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            q_q       <= q_d;
            r_q       <= r_d;
            divisor_q <= divisor_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.q    = q_q;
    assign bus.r    = r_q;

endmodule
